// File: rtl/sram_burst_master.sv
// Burst initiator for the single-port block RAM: streams write bytes in and
// read bytes out through a credit-limited return FIFO.
module sram_burst_master #(
  parameter int ADDR_W       = 14,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [ADDR_W-1:0] cmd_len,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [7:0]        wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [7:0]        rd_data,
  output logic              busy,
  output logic              mem_ce,
  output logic              mem_oce,
  output logic              mem_wre,
  output logic [ADDR_W-1:0] mem_ad,
  output logic [7:0]        mem_din,
  input  logic [7:0]        mem_dout
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FIFO_DEPTH);
  localparam logic [PTR_W+1:0] DEPTH_CW = (PTR_W+2)'(FIFO_DEPTH);

  typedef enum logic [1:0] {IDLE, WRITE, READ, DRAIN} state_t;

  state_t            state, state_next;
  logic [ADDR_W-1:0] addr, remaining;
  logic              cmd_fire, wr_fire, issue;
  logic              has_credit;
  logic [PTR_W+1:0]  credit_used;

  logic [READ_LATENCY-1:0] tag;
  logic                    push;
  logic [PTR_W:0]          inflight;

  logic [7:0]       fifo_mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wptr, rptr;
  logic [PTR_W:0]   fifo_count;
  logic             fifo_empty, fifo_full, pop, bypass, store, take;

  assign mem_oce     = 1'b1;
  assign busy        = (state != IDLE);
  assign credit_used = {1'b0, fifo_count} + {1'b0, inflight};
  assign has_credit  = (credit_used < DEPTH_CW);

  always_comb begin
    state_next = state;
    cmd_ready  = 1'b0;
    wr_ready   = 1'b0;
    issue      = 1'b0;
    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_next = cmd_write ? WRITE : READ;
      end
      WRITE: begin
        wr_ready = 1'b1;
        if (wr_valid && (remaining == '0)) state_next = IDLE;
      end
      READ: begin
        if (has_credit) begin
          issue = 1'b1;
          if (remaining == '0) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (inflight == '0) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  assign cmd_fire = cmd_valid && cmd_ready;
  assign wr_fire  = wr_valid && wr_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= IDLE;
      addr      <= '0;
      remaining <= '0;
      mem_ce    <= 1'b0;
      mem_wre   <= 1'b0;
      mem_ad    <= '0;
      mem_din   <= '0;
    end else begin
      state   <= state_next;
      mem_ce  <= 1'b0;
      mem_wre <= 1'b0;
      if (cmd_fire) begin
        addr      <= cmd_addr;
        remaining <= cmd_len;
      end
      if (wr_fire || issue) begin
        mem_ce  <= 1'b1;
        mem_wre <= wr_fire;
        mem_ad  <= addr;
        addr    <= addr + ADDR_W'(1);
        if (remaining != '0) remaining <= remaining - ADDR_W'(1);
      end
      if (wr_fire) mem_din <= wr_data;
    end
  end

  // Tag follows each read seen on the RAM port until its data appears on mem_dout.
  always_ff @(posedge clk) begin
    if (reset) begin
      tag <= '0;
    end else begin
      tag[0] <= mem_ce && !mem_wre;
      for (int unsigned i = 1; i < READ_LATENCY; i++) tag[i] <= tag[i-1];
    end
  end

  assign push = tag[READ_LATENCY-1];

  always_ff @(posedge clk) begin
    if (reset) begin
      inflight <= '0;
    end else if (issue && !push) begin
      inflight <= inflight + (PTR_W+1)'(1);
    end else if (push && !issue) begin
      inflight <= inflight - (PTR_W+1)'(1);
    end
  end

  // An empty FIFO presents the returning byte directly, so the first byte is
  // visible in the push cycle; a byte popped that same cycle is never stored.
  assign fifo_empty = (fifo_count == '0);
  assign fifo_full  = (fifo_count == DEPTH_C);
  assign rd_valid   = !fifo_empty || push;
  assign rd_data    = !fifo_empty ? fifo_mem[rptr] : (push ? mem_dout : '0);
  assign pop        = rd_valid && rd_ready;
  assign bypass     = push && fifo_empty && pop;
  assign store      = push && !bypass;
  assign take       = pop && !fifo_empty;

  always_ff @(posedge clk) begin
    if (store) fifo_mem[wptr] <= mem_dout;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr       <= '0;
      rptr       <= '0;
      fifo_count <= '0;
    end else begin
      if (store) wptr <= wptr + PTR_W'(1);
      if (take)  rptr <= rptr + PTR_W'(1);
      if (store && !take)      fifo_count <= fifo_count + (PTR_W+1)'(1);
      else if (take && !store) fifo_count <= fifo_count - (PTR_W+1)'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) assert (!(store && !take && fifo_full));
  end

endmodule

// File: tb/tb_sram_burst_master.sv
// Directed bench for sram_burst_master: one DUT in bypass mode, one in pipeline mode,
// each with its own behavioural RAM.
module tb_sram_burst_master;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, sel, init_ram;
  logic        cmd_valid, cmd_write, wr_valid, rd_ready;
  logic [13:0] cmd_addr, cmd_len;
  logic [7:0]  wr_data;

  logic        cmd_ready_a, wr_ready_a, rd_valid_a, busy_a, mem_ce_a, mem_oce_a, mem_wre_a;
  logic [7:0]  rd_data_a, mem_din_a, mem_dout_a;
  logic [13:0] mem_ad_a;
  logic        cmd_ready_b, wr_ready_b, rd_valid_b, busy_b, mem_ce_b, mem_oce_b, mem_wre_b;
  logic [7:0]  rd_data_b, mem_din_b, mem_dout_b;
  logic [13:0] mem_ad_b;

  sram_burst_master #(.ADDR_W(14), .READ_LATENCY(1), .FIFO_DEPTH(4)) dut_a (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && !sel), .cmd_ready(cmd_ready_a), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid && !sel), .wr_ready(wr_ready_a), .wr_data(wr_data),
    .rd_valid(rd_valid_a), .rd_ready(rd_ready && !sel), .rd_data(rd_data_a),
    .busy(busy_a), .mem_ce(mem_ce_a), .mem_oce(mem_oce_a), .mem_wre(mem_wre_a),
    .mem_ad(mem_ad_a), .mem_din(mem_din_a), .mem_dout(mem_dout_a)
  );

  sram_burst_master #(.ADDR_W(14), .READ_LATENCY(2), .FIFO_DEPTH(4)) dut_b (
    .clk(clk), .reset(reset),
    .cmd_valid(cmd_valid && sel), .cmd_ready(cmd_ready_b), .cmd_write(cmd_write),
    .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .wr_valid(wr_valid && sel), .wr_ready(wr_ready_b), .wr_data(wr_data),
    .rd_valid(rd_valid_b), .rd_ready(rd_ready && sel), .rd_data(rd_data_b),
    .busy(busy_b), .mem_ce(mem_ce_b), .mem_oce(mem_oce_b), .mem_wre(mem_wre_b),
    .mem_ad(mem_ad_b), .mem_din(mem_din_b), .mem_dout(mem_dout_b)
  );

  function automatic logic [7:0] pat(input logic [13:0] a);
    return a[7:0] ^ 8'h5A;
  endfunction

  logic [7:0] ram_a [16384];
  logic [7:0] ram_b [16384];
  logic [7:0] q_a, q_b1, q_b2;

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 16384; i++) ram_a[i] <= pat(14'(i));
    end else if (mem_ce_a) begin
      if (mem_wre_a) ram_a[mem_ad_a] <= mem_din_a;
      else           q_a <= ram_a[mem_ad_a];
    end
  end

  always @(posedge clk) begin
    if (init_ram) begin
      for (int i = 0; i < 16384; i++) ram_b[i] <= pat(14'(i));
    end else if (mem_ce_b) begin
      if (mem_wre_b) ram_b[mem_ad_b] <= mem_din_b;
      else           q_b1 <= ram_b[mem_ad_b];
    end
    q_b2 <= q_b1;
  end

  assign mem_dout_a = q_a;
  assign mem_dout_b = q_b2;

  logic        cmd_ready, wr_ready, rd_valid, busy, mem_ce, mem_oce, mem_wre;
  logic [7:0]  rd_data, mem_din;
  logic [13:0] mem_ad;
  assign cmd_ready = sel ? cmd_ready_b : cmd_ready_a;
  assign wr_ready  = sel ? wr_ready_b  : wr_ready_a;
  assign rd_valid  = sel ? rd_valid_b  : rd_valid_a;
  assign rd_data   = sel ? rd_data_b   : rd_data_a;
  assign busy      = sel ? busy_b      : busy_a;
  assign mem_ce    = sel ? mem_ce_b    : mem_ce_a;
  assign mem_oce   = sel ? mem_oce_b   : mem_oce_a;
  assign mem_wre   = sel ? mem_wre_b   : mem_wre_a;
  assign mem_ad    = sel ? mem_ad_b    : mem_ad_a;
  assign mem_din   = sel ? mem_din_b   : mem_din_a;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [22:0] port_q [$];
  int          port_cyc [$];
  logic [7:0]  rd_q [$];
  int          rd_cyc [$];
  int          first_rv = -1;

  always @(negedge clk) begin
    if (!reset) begin
      if (mem_ce) begin
        port_q.push_back({mem_wre, mem_ad, mem_din});
        port_cyc.push_back(cyc);
      end
      if (rd_valid && first_rv < 0) first_rv = cyc;
      if (rd_valid && rd_ready) begin
        rd_q.push_back(rd_data);
        rd_cyc.push_back(cyc);
      end
    end
  end

  int checks = 0;
  int errors = 0;
  int acc_cyc = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic cycle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic clear_mon();
    port_q.delete();
    port_cyc.delete();
    rd_q.delete();
    rd_cyc.delete();
    first_rv = -1;
  endtask

  task automatic send_cmd(input logic w, input logic [13:0] a, input logic [13:0] l);
    int n = 0;
    cmd_valid = 1'b1;
    cmd_write = w;
    cmd_addr  = a;
    cmd_len   = l;
    while (!cmd_ready && n < 100) begin
      cycle(1);
      n++;
    end
    if (!cmd_ready) check("cmd_timeout", 32'(cmd_ready), 32'd1);
    acc_cyc = cyc;
    cycle(1);
    cmd_valid = 1'b0;
  endtask

  task automatic write_bytes(input logic [63:0] bytes, input int n, input bit gap);
    int k;
    for (int i = 0; i < n; i++) begin
      wr_valid = 1'b1;
      wr_data  = bytes[8*i +: 8];
      k = 0;
      while (!wr_ready && k < 50) begin
        cycle(1);
        k++;
      end
      if (!wr_ready) check("wr_timeout", 32'(wr_ready), 32'd1);
      cycle(1);
      if (gap && i < n - 1) begin
        wr_valid = 1'b0;
        cycle(1);
      end
    end
    wr_valid = 1'b0;
  endtask

  task automatic wait_rd(input int n);
    int k = 0;
    while (rd_q.size() < n && k < 200) begin
      cycle(1);
      k++;
    end
    check("rd_count", 32'(rd_q.size()), 32'(n));
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired at cycle %0d", cyc);
    $fatal(1);
  end

  initial begin
    logic [63:0] exp_rd;
    logic [41:0] exp_ad;
    reset = 1'b1; sel = 1'b0; init_ram = 1'b1;
    cmd_valid = 1'b0; cmd_write = 1'b0; cmd_addr = '0; cmd_len = '0;
    wr_valid = 1'b0; wr_data = '0; rd_ready = 1'b0;
    cycle(1);
    init_ram = 1'b0;
    cycle(1);
    check("rst_cmd_ready", 32'(cmd_ready), 32'd1);
    check("rst_wr_ready",  32'(wr_ready),  32'd0);
    check("rst_rd_valid",  32'(rd_valid),  32'd0);
    check("rst_rd_data",   32'(rd_data),   32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_mem_ce",    32'(mem_ce),    32'd0);
    check("rst_mem_wre",   32'(mem_wre),   32'd0);
    check("rst_mem_ad",    32'(mem_ad),    32'd0);
    check("rst_mem_din",   32'(mem_din),   32'd0);
    check("rst_mem_oce",   32'(mem_oce),   32'd1);
    reset = 1'b0;
    cycle(2);

    // write A1..D4 at 0x10, then read back
    clear_mon();
    exp_rd = 64'hD4C3B2A1;
    send_cmd(1'b1, 14'h0010, 14'd3);
    write_bytes(exp_rd, 4, 1'b0);
    check("s1_busy_end", 32'(busy), 32'd0);
    cycle(2);
    check("s1_port_n", 32'(port_q.size()), 32'd4);
    for (int i = 0; i < 4; i++)
      check("s1_port", 32'(port_q[i]), 32'({1'b1, 14'(16 + i), exp_rd[8*i +: 8]}));
    check("s1_port_span", 32'(port_cyc[3] - port_cyc[0]), 32'd3);
    clear_mon();
    rd_ready = 1'b1;
    send_cmd(1'b0, 14'h0010, 14'd3);
    wait_rd(4);
    for (int i = 0; i < 4; i++) check("s1_rd", 32'(rd_q[i]), 32'(exp_rd[8*i +: 8]));
    check("s1_first_lat", 32'(first_rv - acc_cyc), 32'd3);
    cycle(4);

    // write across the top of the address space
    clear_mon();
    exp_rd = 64'h332211;
    exp_ad = {14'h0000, 14'h3FFF, 14'h3FFE};
    send_cmd(1'b1, 14'h3FFE, 14'd2);
    write_bytes(exp_rd, 3, 1'b0);
    cycle(2);
    check("s2_port_n", 32'(port_q.size()), 32'd3);
    for (int i = 0; i < 3; i++)
      check("s2_port", 32'(port_q[i]), 32'({1'b1, exp_ad[14*i +: 14], exp_rd[8*i +: 8]}));
    clear_mon();
    send_cmd(1'b0, 14'h3FFE, 14'd2);
    wait_rd(3);
    for (int i = 0; i < 3; i++) check("s2_rd", 32'(rd_q[i]), 32'(exp_rd[8*i +: 8]));
    cycle(4);

    // back-pressured read: credits limit issue to the FIFO depth
    clear_mon();
    rd_ready = 1'b0;
    send_cmd(1'b0, 14'h0100, 14'd15);
    cycle(20);
    check("s3_issued", 32'(port_q.size()), 32'd4);
    check("s3_rd_valid", 32'(rd_valid), 32'd1);
    rd_ready = 1'b1;
    wait_rd(16);
    for (int i = 0; i < 16; i++) check("s3_rd", 32'(rd_q[i]), 32'(8'(i) ^ 8'h5A));
    check("s3_rate", 32'(rd_cyc[15] - rd_cyc[0]), 32'd15);
    cycle(4);
    check("s3_total_issued", 32'(port_q.size()), 32'd16);

    // write with wr_valid toggling every cycle
    clear_mon();
    exp_rd = 64'h8877665544332211;
    send_cmd(1'b1, 14'h0200, 14'd7);
    write_bytes(exp_rd, 8, 1'b1);
    check("s4_busy_end", 32'(busy), 32'd0);
    cycle(2);
    check("s4_port_n", 32'(port_q.size()), 32'd8);
    for (int i = 0; i < 8; i++)
      check("s4_port", 32'(port_q[i]), 32'({1'b1, 14'(14'h200 + i), exp_rd[8*i +: 8]}));
    check("s4_gap_span", 32'(port_cyc[7] - port_cyc[0]), 32'd14);

    // reset two cycles into a read burst
    clear_mon();
    rd_ready = 1'b0;
    send_cmd(1'b0, 14'h0010, 14'd9);
    cycle(1);
    reset = 1'b1;
    cycle(1);
    check("s5_rd_valid", 32'(rd_valid), 32'd0);
    check("s5_cmd_ready", 32'(cmd_ready), 32'd1);
    check("s5_mem_ce", 32'(mem_ce), 32'd0);
    reset = 1'b0;
    cycle(6);
    check("s5_discard", 32'(first_rv), 32'hFFFF_FFFF);
    clear_mon();
    rd_ready = 1'b1;
    send_cmd(1'b0, 14'h0012, 14'd0);
    wait_rd(1);
    check("s5_rd", 32'(rd_q[0]), 32'h0000_00C3);
    cycle(4);
    check("s5_single", 32'(rd_q.size()), 32'd1);

    // pipeline-mode RAM: same write/read, one extra cycle to first byte
    sel = 1'b1;
    clear_mon();
    exp_rd = 64'hD4C3B2A1;
    send_cmd(1'b1, 14'h0010, 14'd3);
    write_bytes(exp_rd, 4, 1'b0);
    cycle(2);
    clear_mon();
    send_cmd(1'b0, 14'h0010, 14'd3);
    wait_rd(4);
    for (int i = 0; i < 4; i++) check("s6_rd", 32'(rd_q[i]), 32'(exp_rd[8*i +: 8]));
    check("s6_first_lat", 32'(first_rv - acc_cyc), 32'd4);
    cycle(4);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
